// File: rtl/hazard_track_unit.sv
// hazard_track_unit: tracks destination register, RegWrite and MemRead of the
// instructions in EXE/MEM/WB, raises a one-cycle load-use stall against the
// decode instruction, and turns flushed or stalled decode slots into bubbles.
// Optional macro HAZ_STALL_CNT_EN builds a saturating load-use stall counter;
// without it stall_count is tied to zero.
module hazard_track_unit #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] Rd_ID,
    input  logic             RegWrite_ID,
    input  logic             MemRead_ID,
    input  logic [REG_W-1:0] Register1_ID,
    input  logic [REG_W-1:0] Register2_ID,
    input  logic             UseRn_ID,
    input  logic             UseRm_ID,
    input  logic             flush,
    output logic             stall,
    output logic [REG_W-1:0] Aw_EXE,
    output logic [REG_W-1:0] Aw_MEM,
    output logic [REG_W-1:0] Aw_WB,
    output logic             RegWrite_EXE,
    output logic             RegWrite_MEM,
    output logic             RegWrite_WB,
    output logic             MemRead_EXE,
    output logic [15:0]      stall_count
);

    localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

    logic [REG_W-1:0] aw_exe_q, aw_exe_d, aw_mem_q, aw_mem_d, aw_wb_q, aw_wb_d;
    logic             rw_exe_q, rw_exe_d, rw_mem_q, rw_mem_d, rw_wb_q, rw_wb_d;
    logic             mr_exe_q, mr_exe_d;
    logic             raw_hazard;
    logic             bubble;

    // Load in EXE whose destination is read by the decode instruction
    always_comb begin
        raw_hazard = mr_exe_q & rw_exe_q & (aw_exe_q != ZR) &
                     ((UseRn_ID & (Register1_ID == aw_exe_q)) |
                      (UseRm_ID & (Register2_ID == aw_exe_q)));
        stall      = raw_hazard & ~flush & ~reset;
    end

    // Pipeline advance; decode slot becomes a bubble on flush or stall
    always_comb begin
        bubble   = flush | stall;
        aw_wb_d  = aw_mem_q;
        rw_wb_d  = rw_mem_q;
        aw_mem_d = aw_exe_q;
        rw_mem_d = rw_exe_q;
        aw_exe_d = Rd_ID;
        rw_exe_d = RegWrite_ID & (Rd_ID != ZR);
        mr_exe_d = MemRead_ID;
        if (bubble) begin
            aw_exe_d = ZR;
            rw_exe_d = 1'b0;
            mr_exe_d = 1'b0;
        end
    end

    // Stage registers with synchronous reset to bubbles
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_exe_q <= ZR;
            aw_mem_q <= ZR;
            aw_wb_q  <= ZR;
            rw_exe_q <= 1'b0;
            rw_mem_q <= 1'b0;
            rw_wb_q  <= 1'b0;
            mr_exe_q <= 1'b0;
        end else begin
            aw_exe_q <= aw_exe_d;
            aw_mem_q <= aw_mem_d;
            aw_wb_q  <= aw_wb_d;
            rw_exe_q <= rw_exe_d;
            rw_mem_q <= rw_mem_d;
            rw_wb_q  <= rw_wb_d;
            mr_exe_q <= mr_exe_d;
        end
    end

    assign Aw_EXE       = aw_exe_q;
    assign Aw_MEM       = aw_mem_q;
    assign Aw_WB        = aw_wb_q;
    assign RegWrite_EXE = rw_exe_q;
    assign RegWrite_MEM = rw_mem_q;
    assign RegWrite_WB  = rw_wb_q;
    assign MemRead_EXE  = mr_exe_q;

`ifdef HAZ_STALL_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count of stall cycles
    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register, cleared on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_count = cnt_q;
`else
    assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_track_unit.sv
// Directed bench for hazard_track_unit; honours HAZ_STALL_CNT_EN for the counter.
module tb_hazard_track_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rd_ID, Register1_ID, Register2_ID;
    logic        RegWrite_ID, MemRead_ID, UseRn_ID, UseRm_ID, flush;
    logic        stall;
    logic [4:0]  Aw_EXE, Aw_MEM, Aw_WB;
    logic        RegWrite_EXE, RegWrite_MEM, RegWrite_WB, MemRead_EXE;
    logic [15:0] stall_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    hazard_track_unit #(.REG_W(5), .ZERO_REG(31)) dut (
        .clk(clk), .reset(reset),
        .Rd_ID(Rd_ID), .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID),
        .Register1_ID(Register1_ID), .Register2_ID(Register2_ID),
        .UseRn_ID(UseRn_ID), .UseRm_ID(UseRm_ID), .flush(flush),
        .stall(stall),
        .Aw_EXE(Aw_EXE), .Aw_MEM(Aw_MEM), .Aw_WB(Aw_WB),
        .RegWrite_EXE(RegWrite_EXE), .RegWrite_MEM(RegWrite_MEM),
        .RegWrite_WB(RegWrite_WB), .MemRead_EXE(MemRead_EXE),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic [4:0] rd, input logic rw, input logic mr,
                          input logic [4:0] r1, input logic [4:0] r2,
                          input logic urn, input logic urm);
        Rd_ID = rd; RegWrite_ID = rw; MemRead_ID = mr;
        Register1_ID = r1; Register2_ID = r2; UseRn_ID = urn; UseRm_ID = urm;
        #1;
    endtask

    task automatic nop();
        set_id(5'd31, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] cnt_exp();
`ifdef HAZ_STALL_CNT_EN
        return 16'(exp_cnt);
`else
        return 16'd0;
`endif
    endfunction

    initial begin
        // Reset with arbitrary ID contents
        reset = 1'b1; flush = 1'b0;
        set_id(5'd9, 1'b1, 1'b1, 5'd9, 5'd9, 1'b1, 1'b1);
        tick(); tick();
        chk("rst_aw_exe", 16'(Aw_EXE), 16'd31);
        chk("rst_aw_mem", 16'(Aw_MEM), 16'd31);
        chk("rst_aw_wb",  16'(Aw_WB),  16'd31);
        chk("rst_rw", 16'({RegWrite_EXE, RegWrite_MEM, RegWrite_WB, MemRead_EXE}), 16'd0);
        chk("rst_stall", 16'(stall), 16'd0);
        reset = 1'b0;
        nop();
        chk("rst_stall_after", 16'(stall), 16'd0);
        chk("rst_cnt", stall_count, 16'd0);

        // Propagation through EXE/MEM/WB
        set_id(5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        set_id(5'd6, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        set_id(5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        chk("prop_aw_wb",  16'(Aw_WB),  16'd5);
        chk("prop_aw_mem", 16'(Aw_MEM), 16'd6);
        chk("prop_aw_exe", 16'(Aw_EXE), 16'd7);
        chk("prop_rw", 16'({RegWrite_EXE, RegWrite_MEM, RegWrite_WB}), 16'd7);

        // Load-use via Rn: LDUR X3 then ADD X3, X3, ...
        set_id(5'd3, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        set_id(5'd3, 1'b1, 1'b0, 5'd3, 5'd1, 1'b1, 1'b1);
        chk("lu_stall", 16'(stall), 16'd1);
        chk("lu_mr_exe", 16'(MemRead_EXE), 16'd1);
        tick(); exp_cnt++;
        chk("lu_bubble_aw", 16'(Aw_EXE), 16'd31);
        chk("lu_bubble_rw", 16'(RegWrite_EXE), 16'd0);
        chk("lu_load_mem", 16'(Aw_MEM), 16'd3);
        chk("lu_stall_drop", 16'(stall), 16'd0);
        chk("lu_cnt", stall_count, cnt_exp());
        tick();
        nop();
        chk("lu_add_exe", 16'(Aw_EXE), 16'd3);
        chk("lu_add_rw", 16'(RegWrite_EXE), 16'd1);
        chk("lu_add_mr", 16'(MemRead_EXE), 16'd0);
        chk("lu_load_wb", 16'(Aw_WB), 16'd3);
        chk("lu_no_restall", 16'(stall), 16'd0);

        // Load to XZR: sanitised, no stall
        set_id(5'd31, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        set_id(5'd2, 1'b1, 1'b0, 5'd31, 5'd0, 1'b1, 1'b0);
        chk("zr_rw_exe", 16'(RegWrite_EXE), 16'd0);
        chk("zr_mr_exe", 16'(MemRead_EXE), 16'd1);
        chk("zr_stall", 16'(stall), 16'd0);
        tick();

        // Load to X4, reader with Register2=4 but UseRm=0
        set_id(5'd4, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        set_id(5'd2, 1'b1, 1'b0, 5'd0, 5'd4, 1'b1, 1'b0);
        chk("norm_stall", 16'(stall), 16'd0);
        tick();

        // ALU-to-ALU dependency: no stall
        set_id(5'd8, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        set_id(5'd2, 1'b1, 1'b0, 5'd8, 5'd8, 1'b1, 1'b1);
        chk("alu_stall", 16'(stall), 16'd0);
        tick();

        // Dependency on a load already in MEM: no stall
        set_id(5'd10, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        set_id(5'd11, 1'b1, 1'b0, 5'd1, 5'd1, 1'b1, 1'b1); tick();
        set_id(5'd2, 1'b1, 1'b0, 5'd10, 5'd0, 1'b1, 1'b0);
        chk("memload_stall", 16'(stall), 16'd0);
        tick();

        // Flush priority over load-use
        set_id(5'd3, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        set_id(5'd3, 1'b1, 1'b0, 5'd3, 5'd0, 1'b1, 1'b0);
        flush = 1'b1; #1;
        chk("fl_stall", 16'(stall), 16'd0);
        tick();
        flush = 1'b0;
        nop();
        chk("fl_bubble_rw", 16'(RegWrite_EXE), 16'd0);
        chk("fl_bubble_aw", 16'(Aw_EXE), 16'd31);
        chk("fl_cnt", stall_count, cnt_exp());

        // Load-use via Register2
        set_id(5'd12, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        set_id(5'd2, 1'b1, 1'b0, 5'd0, 5'd12, 1'b0, 1'b1);
        chk("rm_stall", 16'(stall), 16'd1);
        tick(); exp_cnt++;
        chk("rm_stall_drop", 16'(stall), 16'd0);
        tick();

        // Back-to-back loads to X13, dependent third instruction
        set_id(5'd13, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        set_id(5'd13, 1'b1, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0);
        chk("b2b_second_load", 16'(stall), 16'd0);
        tick();
        set_id(5'd2, 1'b1, 1'b0, 5'd13, 5'd0, 1'b1, 1'b0);
        chk("b2b_dep_stall", 16'(stall), 16'd1);
        tick(); exp_cnt++;
        chk("b2b_stall_drop", 16'(stall), 16'd0);
        chk("b2b_cnt", stall_count, cnt_exp());
        tick();

        // Reset in the stall cycle
        set_id(5'd14, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        set_id(5'd2, 1'b1, 1'b0, 5'd14, 5'd0, 1'b1, 1'b0);
        chk("rms_stall", 16'(stall), 16'd1);
        reset = 1'b1; #1;
        chk("rms_stall_masked", 16'(stall), 16'd0);
        tick();
        reset = 1'b0;
        exp_cnt = 0;
        #1;
        chk("rms_stall_after", 16'(stall), 16'd0);
        chk("rms_aw", 16'({Aw_EXE, Aw_MEM, Aw_WB}), 16'h7FFF);
        chk("rms_rw", 16'({RegWrite_EXE, RegWrite_MEM, RegWrite_WB, MemRead_EXE}), 16'd0);
        chk("rms_cnt", stall_count, cnt_exp());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
